cdma_despreader: RTL and testbench

- Receive-side counterpart of the CDMA spreader: accepts a serial chip stream and regenerates the same 31-chip Gold code locally.
- Correlates the stream over each bit period, recovers one data bit per 31 chips, and acquires and tracks code phase by chip slipping.
- Sits beside the spreader in the TinyTapeout top, fed from a ui_in pin; outputs go to uio_out.

---
 rtl/cdma_despreader.sv | 186 ++++++++++++++++++
 tb/tb_cdma_despreader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdma_despreader.sv
// cdma_despreader
//   Receive-side CDMA despreader. Regenerates the 31-chip Gold code
//   (LFSR A: x^5+x^2+1, LFSR B: x^5+x^3+x^2+x+1, chip = a[0]^b[0]),
//   counts chip agreements over each bit period and decides one data bit
//   per period. Code phase is acquired by slipping one chip after every
//   erasure in SEARCH; LOCK_COUNT consecutive good decisions enter TRACK,
//   MISS_LIMIT consecutive erasures in TRACK fall back to SEARCH.
//
// Ports
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   chip_i        received chip, sampled when chip_en_i=1
//   chip_en_i     one-cycle chip strobe
//   seed_i[4:0]   LFSR A seed, captured on load_i (0 maps to 5'b00001)
//   load_i        load seed and restart acquisition (beats chip_en_i)
//   data_o        last decided bit (holds across erasures)
//   data_valid_o  one-cycle pulse per good decision
//   lock_o        high while in TRACK
//   corr_o[4:0]   agreement count of the last completed period
//   err_cnt_o[7:0] saturating TRACK-erasure counter (CDMA_DESPREAD_STATS_EN only)
//   gold_o        current local Gold chip
//
// Build option: define CDMA_DESPREAD_STATS_EN to add err_cnt_o.

module cdma_despreader #(
    parameter int unsigned HI_THRESH  = 24,
    parameter int unsigned LO_THRESH  = 7,
    parameter int unsigned LOCK_COUNT = 3,
    parameter int unsigned MISS_LIMIT = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       chip_i,
    input  logic       chip_en_i,
    input  logic [4:0] seed_i,
    input  logic       load_i,
    output logic       data_o,
    output logic       data_valid_o,
    output logic       lock_o,
    output logic [4:0] corr_o,
`ifdef CDMA_DESPREAD_STATS_EN
    output logic [7:0] err_cnt_o,
`endif
    output logic       gold_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_TRACK} state_t;

    state_t     state, state_nx;
    logic [4:0] lfsr_a, lfsr_a_nx;
    logic [4:0] lfsr_b, lfsr_b_nx;
    logic [4:0] phase, phase_nx;
    logic [4:0] acc, acc_nx;
    logic [7:0] good_cnt, good_nx;
    logic [7:0] miss_cnt, miss_nx;
    logic       slip, slip_nx;
    logic       data_nx, valid_nx;
    logic [4:0] corr_nx;
    logic [4:0] acc_sum;
    logic       is_hi, is_lo, decided;
`ifdef CDMA_DESPREAD_STATS_EN
    logic [7:0] err_nx;
`endif

    assign gold_o  = lfsr_a[0] ^ lfsr_b[0];
    assign lock_o  = (state == ST_TRACK);

    // Count including the chip on the bus, so the last chip of a period
    // takes part in its own decision.
    assign acc_sum = acc + 5'(chip_i == gold_o);
    assign is_hi   = (acc_sum >= 5'(HI_THRESH));
    assign is_lo   = (acc_sum <= 5'(LO_THRESH));
    assign decided = is_hi | is_lo;

    always_comb begin
        state_nx  = state;
        lfsr_a_nx = lfsr_a;
        lfsr_b_nx = lfsr_b;
        phase_nx  = phase;
        acc_nx    = acc;
        good_nx   = good_cnt;
        miss_nx   = miss_cnt;
        slip_nx   = slip;
        data_nx   = data_o;
        valid_nx  = 1'b0;
        corr_nx   = corr_o;
`ifdef CDMA_DESPREAD_STATS_EN
        err_nx    = err_cnt_o;
`endif
        if (load_i) begin
            lfsr_a_nx = (seed_i == 5'd0) ? 5'b00001 : seed_i;
            lfsr_b_nx = '1;
            phase_nx  = '0;
            acc_nx    = '0;
            good_nx   = '0;
            miss_nx   = '0;
            slip_nx   = 1'b0;
            state_nx  = ST_SEARCH;
`ifdef CDMA_DESPREAD_STATS_EN
            err_nx    = '0;
`endif
        end else if (chip_en_i && state != ST_IDLE) begin
            if (slip) begin
                // Swallow this chip: the local code now lags one chip more.
                slip_nx = 1'b0;
            end else begin
                lfsr_a_nx = {lfsr_a[0] ^ lfsr_a[2], lfsr_a[4:1]};
                lfsr_b_nx = {^lfsr_b[3:0], lfsr_b[4:1]};
                if (phase == 5'd30) begin
                    phase_nx = '0;
                    acc_nx   = '0;
                    corr_nx  = acc_sum;
                    if (decided) begin
                        data_nx  = !is_hi;
                        valid_nx = 1'b1;
                    end
                    if (state == ST_SEARCH) begin
                        if (decided) begin
                            if (good_cnt + 8'd1 == 8'(LOCK_COUNT)) begin
                                state_nx = ST_TRACK;
                                good_nx  = '0;
                            end else begin
                                good_nx = good_cnt + 8'd1;
                            end
                        end else begin
                            good_nx = '0;
                            slip_nx = 1'b1;
                        end
                    end else begin
                        if (decided) begin
                            miss_nx = '0;
                        end else begin
`ifdef CDMA_DESPREAD_STATS_EN
                            if (err_cnt_o != '1) err_nx = err_cnt_o + 8'd1;
`endif
                            if (miss_cnt + 8'd1 == 8'(MISS_LIMIT)) begin
                                state_nx = ST_SEARCH;
                                miss_nx  = '0;
                            end else begin
                                miss_nx = miss_cnt + 8'd1;
                            end
                        end
                    end
                end else begin
                    phase_nx = phase + 5'd1;
                    acc_nx   = acc_sum;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= ST_IDLE;
            lfsr_a       <= 5'b00001;
            lfsr_b       <= '1;
            phase        <= '0;
            acc          <= '0;
            good_cnt     <= '0;
            miss_cnt     <= '0;
            slip         <= 1'b0;
            data_o       <= 1'b0;
            data_valid_o <= 1'b0;
            corr_o       <= '0;
`ifdef CDMA_DESPREAD_STATS_EN
            err_cnt_o    <= '0;
`endif
        end else begin
            state        <= state_nx;
            lfsr_a       <= lfsr_a_nx;
            lfsr_b       <= lfsr_b_nx;
            phase        <= phase_nx;
            acc          <= acc_nx;
            good_cnt     <= good_nx;
            miss_cnt     <= miss_nx;
            slip         <= slip_nx;
            data_o       <= data_nx;
            data_valid_o <= valid_nx;
            corr_o       <= corr_nx;
`ifdef CDMA_DESPREAD_STATS_EN
            err_cnt_o    <= err_nx;
`endif
        end
    end

endmodule

// File: tb/tb_cdma_despreader.sv
// Self-checking bench for cdma_despreader. A reference model indexes a
// precomputed 31-chip Gold code array (built from the LFSR recurrences)
// and pushes each expected decision into a scoreboard queue; a monitor
// pops and compares whenever data_valid_o pulses.

module tb_cdma_despreader;

    localparam int HI = 24;
    localparam int LO = 7;
    localparam int LOCKN = 3;
    localparam int MISSN = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       chip_i, chip_en_i, load_i;
    logic [4:0] seed_i;
    logic       data_o, data_valid_o, lock_o, gold_o;
    logic [4:0] corr_o;
`ifdef CDMA_DESPREAD_STATS_EN
    logic [7:0] err_cnt_o;
`endif

    always #5 clk = ~clk;

    cdma_despreader #(
        .HI_THRESH(HI), .LO_THRESH(LO), .LOCK_COUNT(LOCKN), .MISS_LIMIT(MISSN)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .chip_i(chip_i), .chip_en_i(chip_en_i),
        .seed_i(seed_i), .load_i(load_i), .data_o(data_o),
        .data_valid_o(data_valid_o), .lock_o(lock_o), .corr_o(corr_o),
`ifdef CDMA_DESPREAD_STATS_EN
        .err_cnt_o(err_cnt_o),
`endif
        .gold_o(gold_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic       d;
        logic [4:0] c;
        logic       l;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    // Reference model state
    bit  mdl_code[31];
    int  mdl_mode;      // 0 idle, 1 search, 2 track
    int  mdl_idx, mdl_acc, mdl_good, mdl_miss, mdl_err, mdl_corr;
    bit  mdl_slip, mdl_data;
    int  tx_pos;
    bit  gs[62];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Gold code from the sequence recurrences a[n+5]=a[n]^a[n+2],
    // b[n+5]=b[n]^b[n+1]^b[n+2]^b[n+3].
    task automatic build_code(input logic [4:0] s);
        bit a[36];
        bit b[36];
        for (int i = 0; i < 5; i++) begin
            a[i] = s[i];
            b[i] = 1'b1;
        end
        for (int n = 0; n < 31; n++) begin
            a[n+5] = a[n] ^ a[n+2];
            b[n+5] = b[n] ^ b[n+1] ^ b[n+2] ^ b[n+3];
            mdl_code[n] = a[n] ^ b[n];
        end
    endtask

    task automatic mdl_reset();
        mdl_mode = 0; mdl_idx = 0; mdl_acc = 0; mdl_good = 0; mdl_miss = 0;
        mdl_err = 0; mdl_slip = 0; mdl_data = 0; mdl_corr = 0;
    endtask

    task automatic mdl_chip(input bit c);
        bit good;
        if (mdl_mode == 0) return;
        if (mdl_slip) begin
            mdl_slip = 0;
            return;
        end
        mdl_acc += (c == mdl_code[mdl_idx]) ? 1 : 0;
        mdl_idx++;
        if (mdl_idx == 31) begin
            mdl_corr = mdl_acc;
            good = (mdl_acc >= HI) || (mdl_acc <= LO);
            if (good) mdl_data = (mdl_acc < HI);
            if (mdl_mode == 1) begin
                if (good) begin
                    mdl_good++;
                    if (mdl_good == LOCKN) begin
                        mdl_mode = 2;
                        mdl_good = 0;
                    end
                end else begin
                    mdl_good = 0;
                    mdl_slip = 1;
                end
            end else begin
                if (good) mdl_miss = 0;
                else begin
                    mdl_miss++;
                    if (mdl_err < 255) mdl_err++;
                    if (mdl_miss == MISSN) begin
                        mdl_mode = 1;
                        mdl_miss = 0;
                    end
                end
            end
            if (good) sb_q.push_back('{d: mdl_data, c: 5'(mdl_acc), l: (mdl_mode == 2)});
            mdl_acc = 0;
            mdl_idx = 0;
        end
    endtask

    task automatic send(input bit c);
        if (mdl_mode == 0) check("gold_idle", int'(gold_o), 0);
        else check("gold", int'(gold_o), int'(mdl_code[mdl_idx]));
        chip_i = c;
        chip_en_i = 1'b1;
        mdl_chip(c);
        @(negedge clk);
        chip_en_i = 1'b0;
        chip_i = 1'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic tx_chips(input int n, input bit b);
        for (int i = 0; i < n; i++) begin
            send(mdl_code[tx_pos] ^ b);
            tx_pos = (tx_pos + 1) % 31;
        end
    endtask

    task automatic tx_flips(input int nflip, input bit b);
        bit fl[31];
        int cnt = 0;
        int k;
        for (int i = 0; i < 31; i++) fl[i] = 0;
        while (cnt < nflip) begin
            k = $urandom_range(0, 30);
            if (!fl[k]) begin
                fl[k] = 1;
                cnt++;
            end
        end
        for (int i = 0; i < 31; i++) begin
            send(mdl_code[tx_pos] ^ b ^ fl[i]);
            tx_pos = (tx_pos + 1) % 31;
        end
    endtask

    task automatic do_load(input logic [4:0] s);
        seed_i = s;
        load_i = 1'b1;
        chip_en_i = 1'($urandom);
        chip_i = 1'($urandom);
        @(negedge clk);
        load_i = 1'b0;
        chip_en_i = 1'b0;
        mdl_reset();
        build_code((s == 5'd0) ? 5'd1 : s);
        mdl_mode = 1;
        tx_pos = 0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && data_valid_o) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_valid: got d=%0d corr=%0d lock=%0d expected no pulse",
                         data_o, corr_o, lock_o);
            end else begin
                mon_e = sb_q.pop_front();
                if ({data_o, corr_o, lock_o} != mon_e) begin
                    n_err++;
                    $display("FAIL sb_decision: got d=%0d corr=%0d lock=%0d expected d=%0d corr=%0d lock=%0d",
                             data_o, corr_o, lock_o, mon_e.d, mon_e.c, mon_e.l);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit b;
        rst_n = 1'b0; chip_i = 0; chip_en_i = 0; load_i = 0; seed_i = '0;
        mdl_reset();
        build_code(5'd1);
        repeat (3) @(negedge clk);
        check("rst_data", int'(data_o), 0);
        check("rst_valid", int'(data_valid_o), 0);
        check("rst_lock", int'(lock_o), 0);
        check("rst_corr", int'(corr_o), 0);
        check("rst_gold", int'(gold_o), 0);
`ifdef CDMA_DESPREAD_STATS_EN
        check("rst_err", int'(err_cnt_o), 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        // IDLE ignores chips
        for (int i = 0; i < 10; i++) send(1'($urandom));
        check("idle_corr", int'(corr_o), 0);

        // Aligned stream, bits 0,1,1,0
        do_load(5'b10011);
        tx_chips(31, 0);
        check("t1_corr0", int'(corr_o), 31);
        tx_chips(31, 1);
        check("t1_corr1", int'(corr_o), 0);
        check("t1_lock_pre", int'(lock_o), 0);
        tx_chips(31, 1);
        check("t1_lock_post", int'(lock_o), 1);
        tx_chips(31, 0);
        check("t1_data3", int'(data_o), 0);

        // Five flipped chips while locked
        tx_flips(5, 0);
        check("flip5_corr", int'(corr_o), 26);
        check("flip5_data", int'(data_o), 0);
        check("flip5_lock", int'(lock_o), 1);

        // Two erasure periods (16 agreements) drop lock
        tx_flips(15, 0);
        check("era1_corr", int'(corr_o), 16);
        check("era1_lock", int'(lock_o), 1);
        tx_flips(15, 0);
        check("era2_corr", int'(corr_o), 16);
        check("era2_lock", int'(lock_o), 0);
`ifdef CDMA_DESPREAD_STATS_EN
        check("era2_errcnt", int'(err_cnt_o), 2);
`endif
        tx_chips(31, 1);
        check("relock_data", int'(data_o), 1);

        // Seed 0 behaves as seed 1 and repeats every 31 chips
        do_load(5'd0);
        for (int i = 0; i < 62; i++) begin
            gs[i] = gold_o;
            send(mdl_code[tx_pos]);
            tx_pos = (tx_pos + 1) % 31;
        end
        for (int i = 0; i < 31; i++) check("seed0_period", int'(gs[i+31]), int'(gs[i]));

        // Stream offset by 5 chips: acquire by slipping
        do_load(5'(1 + $urandom_range(0, 30)));
        tx_pos = 5;
        tx_chips(26, 0);
        for (int p = 0; p < 35; p++) tx_chips(31, 0);
        check("offset_lock", int'(lock_o), 1);
        for (int p = 0; p < 6; p++) begin
            b = 1'($urandom);
            tx_chips(31, b);
            check("offset_data", int'(data_o), int'(b));
        end
`ifdef CDMA_DESPREAD_STATS_EN
        check("offset_errcnt", int'(err_cnt_o), mdl_err);
`endif

        // Mid-period reset while locked
        do_load(5'(1 + $urandom_range(0, 30)));
        for (int p = 0; p < 3; p++) tx_chips(31, 1'($urandom));
        check("mr_lock", int'(lock_o), 1);
        tx_chips(10, 0);
        rst_n = 1'b0;
        #1;
        mdl_reset();
        check("mr_data", int'(data_o), 0);
        check("mr_valid", int'(data_valid_o), 0);
        check("mr_lock0", int'(lock_o), 0);
        check("mr_corr", int'(corr_o), 0);
        check("mr_gold", int'(gold_o), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 40; i++) send(1'($urandom));
        check("mr_idle_corr", int'(corr_o), 0);
        check("mr_idle_lock", int'(lock_o), 0);
        do_load(5'b00111);
        tx_chips(31, 0);
        check("mr_recover_corr", int'(corr_o), 31);

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
